// File: rtl/lms_frame_reader.sv
// Read-side frame reader for the LMS sample FIFO: waits for a full frame, drains it
// through a 2-entry skid buffer and streams it with start/end-of-frame markers.
module lms_frame_reader #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned DEPTH_WIDTH = 10,
  parameter int unsigned FRAME_LEN   = 256,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                   rd_clk,
  input  logic                   rd_rst,
  output logic                   fifo_rd_en,
  input  logic [DATA_WIDTH-1:0]  fifo_rd_data,
  input  logic                   fifo_rd_empty,
  input  logic [DEPTH_WIDTH:0]   fifo_rd_water_level,
  output logic [DATA_WIDTH-1:0]  m_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic                   m_sof,
  output logic                   m_eof,
  output logic                   busy,
  output logic [CNT_WIDTH-1:0]   frame_cnt
);

  localparam int unsigned LW = DEPTH_WIDTH + 1;
  localparam logic [LW-1:0] FRAME_N  = LW'(FRAME_LEN);
  localparam logic [LW-1:0] LAST_IDX = LW'(FRAME_LEN - 1);

  typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_t;

  state_t                 state_q, state_d;
  logic [LW-1:0]          rd_issued_q;
  logic [LW-1:0]          out_idx_q;
  logic                   inflight_q;
  logic [1:0]             occ_q;
  logic [DATA_WIDTH-1:0]  head_q, tail_q;
  logic [CNT_WIDTH-1:0]   frame_cnt_q;

  logic       pop, push, last_pop, credit;
  logic [1:0] level;

  assign m_valid  = (occ_q != 2'd0);
  assign pop      = m_valid & m_ready;
  assign push     = inflight_q;
  assign last_pop = pop & (out_idx_q == LAST_IDX);

  // A read may only be issued if its word is guaranteed a buffer slot on arrival.
  assign level  = occ_q + {1'b0, inflight_q};
  assign credit = (level < 2'd2) | ((level == 2'd2) & pop);

  // Next-state and read-issue logic
  always_comb begin
    state_d    = state_q;
    fifo_rd_en = 1'b0;
    case (state_q)
      IDLE: begin
        if ((fifo_rd_water_level >= FRAME_N) && !fifo_rd_empty) state_d = BURST;
      end
      BURST: begin
        fifo_rd_en = ~fifo_rd_empty & (rd_issued_q < FRAME_N) & credit;
        if (fifo_rd_en && (rd_issued_q == LAST_IDX)) state_d = DRAIN;
      end
      DRAIN: begin
        if (last_pop) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge rd_clk) begin
    if (rd_rst) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Counters and skid buffer; head_q is always the oldest sample
  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      rd_issued_q <= '0;
      out_idx_q   <= '0;
      inflight_q  <= 1'b0;
      occ_q       <= 2'd0;
      head_q      <= '0;
      tail_q      <= '0;
      frame_cnt_q <= '0;
    end else begin
      inflight_q <= fifo_rd_en;

      if (state_q == IDLE)  rd_issued_q <= '0;
      else if (fifo_rd_en)  rd_issued_q <= rd_issued_q + LW'(1);

      if (last_pop) begin
        out_idx_q   <= '0;
        frame_cnt_q <= frame_cnt_q + CNT_WIDTH'(1);
      end else if (pop) begin
        out_idx_q <= out_idx_q + LW'(1);
      end

      case ({push, pop})
        2'b10: begin
          if (occ_q == 2'd0) head_q <= fifo_rd_data;
          else               tail_q <= fifo_rd_data;
          occ_q <= occ_q + 2'd1;
        end
        2'b01: begin
          head_q <= tail_q;
          occ_q  <= occ_q - 2'd1;
        end
        2'b11: begin
          if (occ_q == 2'd1) begin
            head_q <= fifo_rd_data;
          end else begin
            head_q <= tail_q;
            tail_q <= fifo_rd_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign m_data    = head_q;
  assign m_sof     = m_valid & (out_idx_q == '0);
  assign m_eof     = m_valid & (out_idx_q == LAST_IDX);
  assign busy      = (state_q != IDLE);
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_lms_frame_reader.sv
// Directed bench for lms_frame_reader: behavioural FIFO with one-cycle read latency,
// in-order scoreboard of popped samples and per-cycle protocol checks.
module tb_lms_frame_reader;

  logic        rd_clk = 1'b0;
  logic        rd_rst = 1'b1;
  logic        fifo_rd_en;
  logic [15:0] fifo_rd_data = '0;
  logic        fifo_rd_empty;
  logic [10:0] fifo_rd_water_level;
  logic [15:0] m_data;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic        m_sof, m_eof, busy;
  logic [15:0] frame_cnt;

  lms_frame_reader dut (
    .rd_clk(rd_clk), .rd_rst(rd_rst),
    .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data),
    .fifo_rd_empty(fifo_rd_empty), .fifo_rd_water_level(fifo_rd_water_level),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_sof(m_sof), .m_eof(m_eof), .busy(busy), .frame_cnt(frame_cnt)
  );

  always #5 rd_clk = ~rd_clk;

  // Behavioural FIFO: pointers only advance on clock edges (reads) or between edges (writes)
  logic [15:0] mem [0:4095];
  int wr_ptr = 0, rd_ptr = 0;
  bit fifo_clr = 1'b0, emp_force = 1'b0;
  int issued = 0, popped = 0;

  assign fifo_rd_empty       = (wr_ptr == rd_ptr) || emp_force;
  assign fifo_rd_water_level = 11'(wr_ptr - rd_ptr);

  always @(posedge rd_clk) begin
    if (fifo_clr) rd_ptr <= wr_ptr;
    else if (fifo_rd_en) begin
      fifo_rd_data <= mem[rd_ptr];
      rd_ptr       <= rd_ptr + 1;
    end
    if (rd_rst) begin
      issued <= 0;
      popped <= 0;
    end else begin
      if (fifo_rd_en)          issued <= issued + 1;
      if (m_valid && m_ready)  popped <= popped + 1;
    end
  end

  int errors = 0, checks = 0;
  int cyc = 0, exp_ptr = 0, pos = 0, first_cyc = 0, last_cyc = 0, rdy_mode = 0;
  bit prev_stall = 1'b0, saw_rd_en = 1'b0;
  logic [15:0] prev_data = '0;
  logic prev_sof = 1'b0, prev_eof = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push_words(input int n);
    for (int i = 0; i < n; i++) begin
      mem[wr_ptr] = 16'(wr_ptr);
      wr_ptr++;
    end
  endtask

  // One cycle: drive m_ready after the falling edge, then check what the next rising edge will see
  task automatic tick();
    bit rst_edge;
    rst_edge = rd_rst;
    @(negedge rd_clk);
    case (rdy_mode)
      0:       m_ready = 1'b1;
      1:       m_ready = 1'($urandom_range(0, 1));
      default: m_ready = 1'b0;
    endcase
    #1;
    cyc++;
    if (fifo_rd_en) saw_rd_en = 1'b1;
    if (prev_stall && !rst_edge) begin
      chk("stall_valid", 32'(m_valid), 32'(1));
      chk("stall_data", 32'(m_data), 32'(prev_data));
      chk("stall_sof", 32'(m_sof), 32'(prev_sof));
      chk("stall_eof", 32'(m_eof), 32'(prev_eof));
    end
    if (fifo_rd_empty) chk("rd_en_while_empty", 32'(fifo_rd_en), 32'(0));
    chk("occ_plus_inflight_le2", 32'(issued - popped <= 2), 32'(1));
    if (m_valid && m_ready && !rd_rst) begin
      chk("data", 32'(m_data), 32'(mem[exp_ptr]));
      chk("sof", 32'(m_sof), 32'(pos == 0));
      chk("eof", 32'(m_eof), 32'(pos == 255));
      if (pos == 0) first_cyc = cyc;
      if (pos == 255) begin
        last_cyc = cyc;
        pos = 0;
      end else begin
        pos++;
      end
      exp_ptr++;
    end
    prev_stall = m_valid && !m_ready;
    prev_data  = m_data;
    prev_sof   = m_sof;
    prev_eof   = m_eof;
  endtask

  task automatic run_until_frame(input int exp_cnt, input int budget);
    int n;
    n = 0;
    while (frame_cnt !== 16'(exp_cnt) && n < budget) begin
      tick();
      n++;
    end
    chk("frame_cnt", 32'(frame_cnt), 32'(exp_cnt));
    chk("busy_after_frame", 32'(busy), 32'(0));
  endtask

  initial begin
    int n;
    // Reset state
    rd_rst = 1'b1;
    tick();
    tick();
    chk("rst_rd_en", 32'(fifo_rd_en), 32'(0));
    chk("rst_valid", 32'(m_valid), 32'(0));
    chk("rst_data", 32'(m_data), 32'(0));
    chk("rst_sof", 32'(m_sof), 32'(0));
    chk("rst_eof", 32'(m_eof), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_frame_cnt", 32'(frame_cnt), 32'(0));
    rd_rst = 1'b0;

    // Single frame at full rate
    rdy_mode = 0;
    push_words(256);
    run_until_frame(1, 600);
    chk("full_rate_span", 32'(last_cyc - first_cyc), 32'(255));

    // One word short of a frame: must stay idle
    push_words(255);
    saw_rd_en = 1'b0;
    repeat (20) tick();
    chk("short_no_rd_en", 32'(saw_rd_en), 32'(0));
    chk("short_busy", 32'(busy), 32'(0));
    push_words(1);
    n = 0;
    do begin
      tick();
      n++;
    end while (!m_valid && n < 10);
    chk("first_valid_latency", 32'(n), 32'(3));
    run_until_frame(2, 600);

    // Random backpressure
    push_words(256);
    rdy_mode = 1;
    run_until_frame(3, 4000);
    rdy_mode = 0;

    // FIFO reports empty mid-burst
    push_words(256);
    repeat (60) tick();
    chk("mid_burst_busy", 32'(busy), 32'(1));
    emp_force = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("forced_empty_rd_en", 32'(fifo_rd_en), 32'(0));
    end
    emp_force = 1'b0;
    run_until_frame(4, 600);

    // Two frames back to back
    push_words(512);
    run_until_frame(5, 600);
    run_until_frame(6, 600);
    chk("frame_aligned", 32'(pos), 32'(0));

    // Reset mid-frame after 100 samples
    push_words(256);
    n = 0;
    while (pos != 100 && n < 1000) begin
      tick();
      n++;
    end
    chk("reached_100_pops", 32'(pos), 32'(100));
    rdy_mode = 2;
    tick();
    rd_rst   = 1'b1;
    fifo_clr = 1'b1;
    tick();
    rd_rst   = 1'b0;
    fifo_clr = 1'b0;
    chk("midrst_rd_en", 32'(fifo_rd_en), 32'(0));
    chk("midrst_valid", 32'(m_valid), 32'(0));
    chk("midrst_data", 32'(m_data), 32'(0));
    chk("midrst_sof", 32'(m_sof), 32'(0));
    chk("midrst_eof", 32'(m_eof), 32'(0));
    chk("midrst_busy", 32'(busy), 32'(0));
    chk("midrst_frame_cnt", 32'(frame_cnt), 32'(0));
    exp_ptr = wr_ptr;
    pos = 0;
    push_words(256);
    rdy_mode = 0;
    run_until_frame(1, 600);
    chk("post_rst_aligned", 32'(pos), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
